core_onchip_mem_dp: RTL and testbench

CORE_ONCHIP_MEM_DP -- requirements
Module: core_onchip_mem_dp

---
 rtl/core_onchip_mem_dp_if.sv | 25 ++
 rtl/core_onchip_mem_dp.sv | 132 +++++++++++++
 tb/tb_core_onchip_mem_dp.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_onchip_mem_dp_if.sv
// One slave port of the dual-port on-chip memory: request, write data and read-return signals.
interface core_onchip_mem_dp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 13
);
    logic [ADDR_W-1:0]   address;
    logic [DATA_W/8-1:0] byteenable;
    logic                chipselect;
    logic                read;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic [DATA_W-1:0]   readdata;
    logic                readdatavalid;
    logic                waitrequest;

    modport master (
        output address, byteenable, chipselect, read, write, writedata,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  address, byteenable, chipselect, read, write, writedata,
        output readdata, readdatavalid, waitrequest
    );
endinterface

// File: rtl/core_onchip_mem_dp.sv
// Dual-port byte-enabled on-chip RAM: s1 wins same-address write collisions, cross-port
// read-during-write forwards new bytes, and reads return after a 1- or 2-stage pipeline.
module core_onchip_mem_dp #(
    parameter int    DATA_W       = 32,
    parameter int    ADDR_W       = 13,
    parameter int    READ_LATENCY = 1,
    parameter string INIT_FILE    = "onchip_mem.hex"
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clken,
    input  logic                reset_req,
    core_onchip_mem_dp_if.slave s1,
    core_onchip_mem_dp_if.slave s2
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NB    = DATA_W / 8;

    if (DATA_W % 8 != 0) begin : g_bad_width
        $error("DATA_W must be a multiple of 8");
    end

    logic                   w_en;
    logic                   w_collide;
    logic [1:0][ADDR_W-1:0] w_addr;
    logic [1:0][NB-1:0]     w_be;
    logic [1:0][DATA_W-1:0] w_wdata;
    logic [1:0]             w_req;
    logic [1:0]             w_is_wr;
    logic [1:0]             w_wait;
    logic [1:0]             w_acc;
    logic [1:0]             w_wr;
    logic [1:0]             w_rd;
    logic [1:0][DATA_W-1:0] w_rdata;
    logic [1:0]             w_vld_out;
    logic [1:0][DATA_W-1:0] w_dat_out;

    logic [DATA_W-1:0]      r_mem [DEPTH];
    logic [1:0]             r_vld1;
    logic [1:0][DATA_W-1:0] r_dat1;

    assign w_en    = clken & ~reset_req;
    assign w_addr  = {s2.address, s1.address};
    assign w_be    = {s2.byteenable, s1.byteenable};
    assign w_wdata = {s2.writedata, s1.writedata};
    assign w_req   = {s2.chipselect & (s2.read | s2.write), s1.chipselect & (s1.read | s1.write)};
    // read+write together on one port is resolved as a write
    assign w_is_wr = {s2.write, s1.write};

    assign w_collide = s1.chipselect & s1.write & s2.chipselect & s2.write
                     & (s1.address == s2.address);

    assign w_wait[0] = reset | ~w_en;
    assign w_wait[1] = reset | ~w_en | w_collide;
    assign s1.waitrequest = w_wait[0];
    assign s2.waitrequest = w_wait[1];

    assign w_acc = w_req & ~w_wait;
    assign w_wr  = w_acc & w_is_wr;
    assign w_rd  = w_acc & ~w_is_wr;

    // INIT_FILE names the power-up image for the device memory-initialisation flow.
    // NOTE: the array has no reset branch; clearing it would block RAM inference and reset must keep contents.
    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            for (int b = 0; b < NB; b++) begin
                if (w_wr[p] && w_be[p][b]) begin
                    r_mem[w_addr[p]][b*8 +: 8] <= w_wdata[p][b*8 +: 8];
                end
            end
        end
    end

    // NOTE: old contents are assigned first so every byte has a value on every path (no latch).
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_rdata[p] = r_mem[w_addr[p]];
            for (int b = 0; b < NB; b++) begin
                if (w_wr[1-p] && (w_addr[1-p] == w_addr[p]) && w_be[1-p][b]) begin
                    w_rdata[p][b*8 +: 8] = w_wdata[1-p][b*8 +: 8];
                end
            end
        end
    end

    // NOTE: non-blocking assignments so each pipeline stage samples its pre-edge inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld1 <= '0;
            r_dat1 <= '0;
        end else if (w_en) begin
            r_vld1 <= w_rd;
            for (int p = 0; p < 2; p++) begin
                if (w_rd[p]) begin
                    r_dat1[p] <= w_rdata[p];
                end
            end
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic [1:0]             r_vld2;
        logic [1:0][DATA_W-1:0] r_dat2;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_vld2 <= '0;
                r_dat2 <= '0;
            end else if (w_en) begin
                r_vld2 <= r_vld1;
                for (int p = 0; p < 2; p++) begin
                    if (r_vld1[p]) begin
                        r_dat2[p] <= r_dat1[p];
                    end
                end
            end
        end

        assign w_vld_out = r_vld2;
        assign w_dat_out = r_dat2;
    end else if (READ_LATENCY == 1) begin : g_lat1
        assign w_vld_out = r_vld1;
        assign w_dat_out = r_dat1;
    end else begin : g_bad_latency
        $error("READ_LATENCY must be 1 or 2");
    end

    assign s1.readdatavalid = w_vld_out[0];
    assign s1.readdata      = w_dat_out[0];
    assign s2.readdatavalid = w_vld_out[1];
    assign s2.readdata      = w_dat_out[1];
endmodule

// File: tb/tb_core_onchip_mem_dp.sv
// Drives a READ_LATENCY=1 and a READ_LATENCY=2 instance with identical stimulus and scores both.
module tb_core_onchip_mem_dp;
    localparam int DW = 32;
    localparam int AW = 4;
    localparam int NW = 2 ** AW;

    typedef struct packed {
        logic          cs;
        logic          rd;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW/8-1:0] be;
        logic [DW-1:0] wdata;
    } req_t;

    typedef struct {
        req_t r1;
        req_t r2;
        logic ck;
        logic rq;
        logic rs;
        logic w1;
        logic w2;
    } vec_t;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic clken;
    logic reset_req;
    req_t req [2];

    logic [1:0][1:0]         rdv;
    logic [1:0][1:0]         wrq;
    logic [1:0][1:0][DW-1:0] rdd;

    int            n_vec  = 0;
    int            n_err  = 0;
    int            en_cnt = 0;
    logic          en_last;
    logic          rst_last;
    logic [DW-1:0] model [NW];
    exp_t          sbq [4][$];
    logic          held_v [4];
    logic [DW-1:0] held_x [4];

    always #5 clk = ~clk;

    core_onchip_mem_dp_if #(.DATA_W(DW), .ADDR_W(AW)) if_l1 [2] ();
    core_onchip_mem_dp_if #(.DATA_W(DW), .ADDR_W(AW)) if_l2 [2] ();

    core_onchip_mem_dp #(.DATA_W(DW), .ADDR_W(AW), .READ_LATENCY(1), .INIT_FILE("")) u_dut_l1 (
        .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req),
        .s1(if_l1[0]), .s2(if_l1[1])
    );

    core_onchip_mem_dp #(.DATA_W(DW), .ADDR_W(AW), .READ_LATENCY(2), .INIT_FILE("")) u_dut_l2 (
        .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req),
        .s1(if_l2[0]), .s2(if_l2[1])
    );

    for (genvar p = 0; p < 2; p++) begin : g_conn
        assign if_l1[p].chipselect = req[p].cs;
        assign if_l1[p].read       = req[p].rd;
        assign if_l1[p].write      = req[p].wr;
        assign if_l1[p].address    = req[p].addr;
        assign if_l1[p].byteenable = req[p].be;
        assign if_l1[p].writedata  = req[p].wdata;
        assign if_l2[p].chipselect = req[p].cs;
        assign if_l2[p].read       = req[p].rd;
        assign if_l2[p].write      = req[p].wr;
        assign if_l2[p].address    = req[p].addr;
        assign if_l2[p].byteenable = req[p].be;
        assign if_l2[p].writedata  = req[p].wdata;
        assign rdv[0][p] = if_l1[p].readdatavalid;
        assign rdd[0][p] = if_l1[p].readdata;
        assign wrq[0][p] = if_l1[p].waitrequest;
        assign rdv[1][p] = if_l2[p].readdatavalid;
        assign rdd[1][p] = if_l2[p].readdata;
        assign wrq[1][p] = if_l2[p].waitrequest;
    end

    function automatic req_t op_idle();
        op_idle = '0;
    endfunction

    function automatic req_t op_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW/8-1:0] be);
        op_wr = '{cs: 1'b1, rd: 1'b0, wr: 1'b1, addr: a, be: be, wdata: d};
    endfunction

    function automatic req_t op_rd(input logic [AW-1:0] a);
        op_rd = '{cs: 1'b1, rd: 1'b1, wr: 1'b0, addr: a, be: '0, wdata: '0};
    endfunction

    function automatic vec_t mk(input req_t r1, input req_t r2, input logic w1, input logic w2,
                                input logic ck = 1'b1, input logic rq = 1'b0, input logic rs = 1'b0);
        mk = '{r1: r1, r2: r2, ck: ck, rq: rq, rs: rs, w1: w1, w2: w2};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, want);
        end
    endtask

    task automatic mon(input int d, input int p);
        int            i;
        logic          ev;
        logic [DW-1:0] ex;
        i = d * 2 + p;
        if (rst_last) begin
            ev = 1'b0;
            ex = '0;
        end else if (!en_last) begin
            ev = held_v[i];
            ex = held_x[i];
        end else if (sbq[i].size() > 0 && sbq[i][0].due == en_cnt) begin
            ev = 1'b1;
            ex = sbq[i][0].data;
            void'(sbq[i].pop_front());
        end else begin
            ev = 1'b0;
            ex = held_x[i];
        end
        check($sformatf("readout L%0d s%0d", d + 1, p + 1), 64'({rdv[d][p], rdd[d][p]}), 64'({ev, ex}));
        held_v[i] = ev;
        held_x[i] = ex;
    endtask

    // Inputs are already applied; checks waitrequest, updates the model, clocks once, scores outputs.
    task automatic step(input logic ew1, input logic ew2);
        logic       en;
        logic [1:0] ew;
        logic [1:0] acc;
        en = clken & ~reset_req;
        ew = {ew2, ew1};
        #1;
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++)
                check($sformatf("waitreq L%0d s%0d", d + 1, p + 1), 64'(wrq[d][p]), 64'(ew[p]));
        for (int p = 0; p < 2; p++) begin
            acc[p] = ~ew[p] & req[p].cs & (req[p].rd | req[p].wr);
            if (acc[p] && req[p].wr)
                for (int b = 0; b < DW/8; b++)
                    if (req[p].be[b]) model[req[p].addr][b*8 +: 8] = req[p].wdata[b*8 +: 8];
        end
        @(posedge clk);
        rst_last = reset;
        en_last  = en;
        if (reset) begin
            for (int i = 0; i < 4; i++) sbq[i].delete();
        end else if (en) begin
            en_cnt++;
        end
        for (int p = 0; p < 2; p++)
            if (acc[p] && req[p].rd && !req[p].wr)
                for (int d = 0; d < 2; d++)
                    sbq[d*2 + p].push_back('{data: model[req[p].addr], due: en_cnt + d});
        @(negedge clk);
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++)
                mon(d, p);
    endtask

    task automatic apply(input vec_t v);
        req[0]    = v.r1;
        req[1]    = v.r2;
        clken     = v.ck;
        reset_req = v.rq;
        reset     = v.rs;
        step(v.w1, v.w2);
    endtask

    task automatic cyc(input req_t r1, input req_t r2, input logic w1, input logic w2,
                       input logic ck = 1'b1, input logic rq = 1'b0, input logic rs = 1'b0);
        apply(mk(r1, r2, w1, w2, ck, rq, rs));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[$];
        req_t r;
        int   pulses;

        for (int i = 0; i < 4; i++) begin
            held_v[i] = 1'b0;
            held_x[i] = '0;
        end
        reset     = 1'b1;
        clken     = 1'b1;
        reset_req = 1'b0;
        req[0]    = op_idle();
        req[1]    = op_idle();

        tbl.push_back(mk(op_idle(), op_idle(), 1'b1, 1'b1, 1'b1, 1'b0, 1'b1));
        tbl.push_back(mk(op_idle(), op_idle(), 1'b1, 1'b1, 1'b1, 1'b0, 1'b1));
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(op_wr(AW'(i), DW'(32'hC0DE_0000 + i * 32'h0101), 4'hF),
                             op_wr(AW'(i + 8), DW'(32'h5A00_0000 + i * 32'h0011_0000), 4'hF), 1'b0, 1'b0));
        for (int i = 0; i < 16; i++)
            tbl.push_back(mk(op_rd(AW'(i)), op_rd(AW'(15 - i)), 1'b0, 1'b0));
        tbl.push_back(mk(op_wr(2, 32'h1234_5678, 4'hF), op_rd(9), 1'b0, 1'b0));
        tbl.push_back(mk(op_rd(2), op_idle(), 1'b0, 1'b0));
        r = op_wr(2, 32'hDEAD_BEEF, 4'hC);
        r.rd = 1'b1;
        tbl.push_back(mk(r, op_rd(2), 1'b0, 1'b0));
        tbl.push_back(mk(op_rd(2), op_idle(), 1'b0, 1'b0));
        r = op_rd(3);
        r.cs = 1'b0;
        tbl.push_back(mk(r, op_idle(), 1'b0, 1'b0));
        tbl.push_back(mk(op_rd(4), op_wr(4, 32'hFFFF_FFFF, 4'hF), 1'b1, 1'b1, 1'b1, 1'b1, 1'b0));
        tbl.push_back(mk(op_rd(4), op_wr(4, 32'hFFFF_FFFF, 4'hF), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(op_wr(4, 32'hFFFF_FFFF, 4'h0), op_idle(), 1'b0, 1'b0));
        tbl.push_back(mk(op_rd(4), op_idle(), 1'b0, 1'b0));
        tbl.push_back(mk(op_rd(1), op_wr(1, 32'h0BAD_F00D, 4'h9), 1'b0, 1'b0));
        tbl.push_back(mk(op_idle(), op_idle(), 1'b0, 1'b0));
        tbl.push_back(mk(op_idle(), op_idle(), 1'b0, 1'b0));

        foreach (tbl[i]) apply(tbl[i]);

        // byte-lane write then cross-port read
        cyc(op_wr(5, 32'h1122_3344, 4'hF), op_idle(), 1'b0, 1'b0);
        cyc(op_wr(5, 32'hAABB_CCDD, 4'h5), op_idle(), 1'b0, 1'b0);
        cyc(op_idle(), op_rd(5), 1'b0, 1'b0);
        check("byte write L1", 64'({rdv[0][1], rdd[0][1]}), 64'({1'b1, 32'h11BB_33DD}));
        cyc(op_idle(), op_idle(), 1'b0, 1'b0);
        check("byte write L2", 64'({rdv[1][1], rdd[1][1]}), 64'({1'b1, 32'h11BB_33DD}));

        // same-address write collision: s2 stalls one cycle then lands
        cyc(op_wr(7, 32'hA, 4'hF), op_wr(7, 32'hB, 4'hF), 1'b0, 1'b1);
        cyc(op_idle(), op_wr(7, 32'hB, 4'hF), 1'b0, 1'b0);
        cyc(op_rd(7), op_idle(), 1'b0, 1'b0);
        check("collision L1", 64'({rdv[0][0], rdd[0][0]}), 64'({1'b1, 32'hB}));

        // cross-port read during partial write
        cyc(op_wr(3, 32'h0, 4'hF), op_idle(), 1'b0, 1'b0);
        cyc(op_wr(3, 32'hFFFF_FFFF, 4'h3), op_rd(3), 1'b0, 1'b0);
        check("rdw L1", 64'({rdv[0][1], rdd[0][1]}), 64'({1'b1, 32'h0000_FFFF}));
        cyc(op_idle(), op_idle(), 1'b0, 1'b0);
        check("rdw L2", 64'({rdv[1][1], rdd[1][1]}), 64'({1'b1, 32'h0000_FFFF}));

        // back-to-back burst on the two-stage instance
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(op_rd(AW'(i)), op_idle(), 1'b0, 1'b0);
            if (i == 0) check("L2 no early valid", 64'(rdv[1][0]), 64'(0));
            if (rdv[1][0]) pulses++;
        end
        for (int i = 0; i < 2; i++) begin
            cyc(op_idle(), op_idle(), 1'b0, 1'b0);
            if (rdv[1][0]) pulses++;
        end
        check("L2 burst pulses", 64'(pulses), 64'(8));

        // clock-enable stall inside a burst
        for (int i = 8; i < 12; i++) cyc(op_rd(AW'(i)), op_idle(), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(op_rd(12), op_idle(), 1'b1, 1'b1, 1'b0);
            check("stall hold L2", 64'(rdv[1][0]), 64'(1));
        end
        for (int i = 12; i < 16; i++) cyc(op_rd(AW'(i)), op_idle(), 1'b0, 1'b0);
        cyc(op_idle(), op_idle(), 1'b0, 1'b0);
        cyc(op_idle(), op_idle(), 1'b0, 1'b0);

        // reset while a two-stage read is in flight
        cyc(op_rd(6), op_idle(), 1'b0, 1'b0);
        cyc(op_idle(), op_idle(), 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        check("reset kill L2", 64'({rdv[1][0], rdd[1][0]}), 64'(0));
        cyc(op_rd(6), op_idle(), 1'b0, 1'b0);
        cyc(op_idle(), op_idle(), 1'b0, 1'b0);
        check("post-reset L2", 64'({rdv[1][0], rdd[1][0]}), 64'({1'b1, model[6]}));

        for (int i = 0; i < 3; i++) cyc(op_idle(), op_idle(), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) check($sformatf("scoreboard drained %0d", i), 64'(sbq[i].size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
